// File: rtl/fixed_matmul_pkg.sv
// Shared types and sizing helpers for the tiled fixed-point matmul accumulator.
package fixed_matmul_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    BIAS  = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Headroom for IN_SIZE*IN_DEPTH products plus one bit for the bias add.
  function automatic int acc_width(input int in1_w, input int in2_w, input int in_size,
                                   input int in_depth, input int has_bias);
    return in1_w + in2_w + $clog2(in_size * in_depth) + has_bias;
  endfunction

endpackage

// File: rtl/fixed_matmul_acc_core_round_sat.sv
// Combinational per-element requantisation: optional round-half-up, arithmetic
// shift to the output fractional position, then clamp or wrap to OUT_WIDTH.
module fixed_round_sat
  import fixed_matmul_pkg::*;
#(
  parameter int ACC_WIDTH      = 20,
  parameter int ACC_FRAC       = 8,
  parameter int OUT_WIDTH      = 8,
  parameter int OUT_FRAC_WIDTH = 4,
  parameter int ROUND_MODE     = ROUND_HALF_UP,
  parameter int SATURATE       = 1
) (
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  output logic        [OUT_WIDTH-1:0] data_out
);

  localparam int SHIFT    = ACC_FRAC - OUT_FRAC_WIDTH;
  // One guard bit above the accumulator so the rounding add cannot overflow.
  localparam int CW       = (ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH + 1 : OUT_WIDTH + 1;
  localparam int HALF_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [CW-1:0] HALF =
    (ROUND_MODE == ROUND_HALF_UP && SHIFT > 0) ? (CW'(1) << HALF_POS) : '0;
  localparam logic signed [CW-1:0] OUT_MAX = (CW'(1) << (OUT_WIDTH - 1)) - CW'(1);
  localparam logic signed [CW-1:0] OUT_MIN = -(CW'(1) << (OUT_WIDTH - 1));

  logic signed [CW-1:0] ext;
  logic signed [CW-1:0] rounded;
  logic signed [CW-1:0] shifted;

  always_comb begin
    ext      = CW'(acc_in);
    rounded  = ext + HALF;
    shifted  = rounded >>> SHIFT;
    data_out = OUT_WIDTH'(shifted);
    if (SATURATE != 0) begin
      if (shifted > OUT_MAX) data_out = OUT_WIDTH'(OUT_MAX);
      else if (shifted < OUT_MIN) data_out = OUT_WIDTH'(OUT_MIN);
    end
  end

endmodule

// File: rtl/fixed_matmul_acc_core.sv
// Tiled fixed-point matmul: accumulates IN_DEPTH beats of partial products,
// optionally adds a bias tile, then rounds/saturates into a decoupled output register.
module fixed_matmul_acc_core
  import fixed_matmul_pkg::*;
#(
  parameter int IN1_WIDTH       = 8,
  parameter int IN1_FRAC_WIDTH  = 4,
  parameter int IN2_WIDTH       = 8,
  parameter int IN2_FRAC_WIDTH  = 4,
  parameter int BIAS_WIDTH      = 8,
  parameter int BIAS_FRAC_WIDTH = 4,
  parameter int OUT_WIDTH       = 8,
  parameter int OUT_FRAC_WIDTH  = 4,
  parameter int OUT_ROWS        = 2,
  parameter int IN_SIZE         = 2,
  parameter int OUT_COLUMNS     = 2,
  parameter int IN_DEPTH        = 4,
  parameter int HAS_BIAS        = 1,
  parameter int ROUND_MODE      = ROUND_HALF_UP,
  parameter int SATURATE        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN1_WIDTH-1:0]  data_in1 [OUT_ROWS*IN_SIZE],
  input  logic                  data_in1_valid,
  output logic                  data_in1_ready,
  input  logic [IN2_WIDTH-1:0]  data_in2 [IN_SIZE*OUT_COLUMNS],
  input  logic                  data_in2_valid,
  output logic                  data_in2_ready,
  input  logic [BIAS_WIDTH-1:0] bias [OUT_ROWS*OUT_COLUMNS],
  input  logic                  bias_valid,
  output logic                  bias_ready,
  output logic [OUT_WIDTH-1:0]  data_out [OUT_ROWS*OUT_COLUMNS],
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output state_t                dbg_state
);

  localparam int ACC_WIDTH  = acc_width(IN1_WIDTH, IN2_WIDTH, IN_SIZE, IN_DEPTH, HAS_BIAS);
  localparam int ACC_FRAC   = IN1_FRAC_WIDTH + IN2_FRAC_WIDTH;
  localparam int BIAS_SHIFT = ACC_FRAC - BIAS_FRAC_WIDTH;
  localparam int N_OUT      = OUT_ROWS * OUT_COLUMNS;
  localparam int CNT_W      = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_DEPTH - 1);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            beat_cnt_q;
  logic signed [ACC_WIDTH-1:0] acc_q    [N_OUT];
  logic signed [ACC_WIDTH-1:0] beat_sum [N_OUT];
  logic signed [ACC_WIDTH-1:0] bias_ext [N_OUT];
  logic [OUT_WIDTH-1:0]        rs_out   [N_OUT];
  logic [OUT_WIDTH-1:0]        out_q    [N_OUT];
  logic                        out_valid_q;
  logic                        beat_fire, bias_fire, out_load, last_beat;

  function automatic logic signed [ACC_WIDTH-1:0] mul(input logic signed [IN1_WIDTH-1:0] x,
                                                      input logic signed [IN2_WIDTH-1:0] y);
    logic signed [ACC_WIDTH-1:0] xe, ye;
    xe = ACC_WIDTH'(x);
    ye = ACC_WIDTH'(y);
    return xe * ye;
  endfunction

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // in1/in2 are joined (one ready, both valids needed); ready never depends on valid,
  // and all readys are low while rst_n is asserted.
  assign data_in1_ready = rst_n && (state_q == ACCUM);
  assign data_in2_ready = data_in1_ready;
  assign bias_ready     = (HAS_BIAS != 0) && rst_n && (state_q == BIAS);
  assign beat_fire      = data_in1_ready && data_in1_valid && data_in2_valid;
  assign bias_fire      = bias_ready && bias_valid;
  assign out_load       = (state_q == DONE) && (!out_valid_q || data_out_ready);
  assign last_beat      = (beat_cnt_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (beat_fire && last_beat) state_d = (HAS_BIAS != 0) ? BIAS : DONE;
      BIAS:    if (bias_fire) state_d = DONE;
      DONE:    if (out_load) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    for (int e = 0; e < N_OUT; e++) begin
      beat_sum[e] = '0;
      bias_ext[e] = ACC_WIDTH'($signed(bias[e])) <<< BIAS_SHIFT;
    end
    for (int r = 0; r < OUT_ROWS; r++) begin
      for (int c = 0; c < OUT_COLUMNS; c++) begin
        for (int k = 0; k < IN_SIZE; k++) begin
          beat_sum[r*OUT_COLUMNS+c] = beat_sum[r*OUT_COLUMNS+c] +
            mul($signed(data_in1[r*IN_SIZE+k]), $signed(data_in2[k*OUT_COLUMNS+c]));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (beat_fire) beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_W'(1);
    end
  end

  // Beat 0 loads instead of accumulating, so no clear cycle between tiles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < N_OUT; e++) acc_q[e] <= '0;
    end else if (beat_fire) begin
      for (int e = 0; e < N_OUT; e++)
        acc_q[e] <= (beat_cnt_q == '0) ? beat_sum[e] : acc_q[e] + beat_sum[e];
    end else if (bias_fire) begin
      for (int e = 0; e < N_OUT; e++) acc_q[e] <= acc_q[e] + bias_ext[e];
    end
  end

  for (genvar e = 0; e < N_OUT; e++) begin : g_rs
    fixed_round_sat #(
      .ACC_WIDTH     (ACC_WIDTH),
      .ACC_FRAC      (ACC_FRAC),
      .OUT_WIDTH     (OUT_WIDTH),
      .OUT_FRAC_WIDTH(OUT_FRAC_WIDTH),
      .ROUND_MODE    (ROUND_MODE),
      .SATURATE      (SATURATE)
    ) u_rs (
      .acc_in  (acc_q[e]),
      .data_out(rs_out[e])
    );
  end

  // A new tile may load in the same cycle the held one drains: back-to-back output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      for (int e = 0; e < N_OUT; e++) out_q[e] <= '0;
    end else if (out_load) begin
      out_valid_q <= 1'b1;
      out_q       <= rs_out;
    end else if (data_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign data_out       = out_q;
  assign data_out_valid = out_valid_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/fixed_matmul_acc_core.md
Name: fixed_matmul_acc_core

Overview:
Tiled fixed-point matrix-multiply core. It computes one OUT_ROWS x OUT_COLUMNS output tile by accumulating IN_DEPTH beats of (OUT_ROWS x IN_SIZE) x (IN_SIZE x OUT_COLUMNS) partial products, optionally adds a bias tile, then rounds and saturates to the output format. A decoupled output register lets accumulation of the next tile overlap with back-pressure on the current tile. It sits between the linear/attention dataflow front-ends and the downstream cast/activation stages.

Parameters:
IN1_WIDTH, 8, data_in1 element width
IN1_FRAC_WIDTH, 4, data_in1 fractional bits
IN2_WIDTH, 8, data_in2 element width
IN2_FRAC_WIDTH, 4, data_in2 fractional bits
BIAS_WIDTH, 8, bias element width
BIAS_FRAC_WIDTH, 4, bias fractional bits; must be <= IN1_FRAC_WIDTH+IN2_FRAC_WIDTH
OUT_WIDTH, 8, output element width
OUT_FRAC_WIDTH, 4, output fractional bits; must be <= IN1_FRAC_WIDTH+IN2_FRAC_WIDTH
OUT_ROWS, 2, tile rows (n)
IN_SIZE, 2, inner-dimension elements per beat (m slice)
OUT_COLUMNS, 2, tile columns (k)
IN_DEPTH, 4, beats per tile; must be >= 1
HAS_BIAS, 1, 1 = consume one bias tile per output tile
ROUND_MODE, 1, 0 = truncate (floor), 1 = round-half-up
SATURATE, 1, 1 = clamp to OUT range, 0 = wrap (keep low bits)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
data_in1  in  [IN1_WIDTH-1:0] x OUT_ROWS*IN_SIZE  element [r*IN_SIZE+k], signed
data_in1_valid  in  1  beat valid
data_in1_ready  out  1  beat accepted when valid&ready
data_in2  in  [IN2_WIDTH-1:0] x IN_SIZE*OUT_COLUMNS  element [k*OUT_COLUMNS+c], signed
data_in2_valid  in  1  beat valid
data_in2_ready  out  1  beat accepted
bias  in  [BIAS_WIDTH-1:0] x OUT_ROWS*OUT_COLUMNS  element [r*OUT_COLUMNS+c], signed
bias_valid  in  1  bias tile valid
bias_ready  out  1  bias accepted
data_out  out  [OUT_WIDTH-1:0] x OUT_ROWS*OUT_COLUMNS  element [r*OUT_COLUMNS+c]
data_out_valid  out  1  tile valid
data_out_ready  in  1  downstream accept

Behaviour:
- Reset (async, rst_n low): state=ACCUM, beat counter=0, accumulators=0, out register=0, data_out_valid=0. All readys deassert while rst_n is low. Reset mid-tile discards the partial tile and any held output.
- ACC_WIDTH = IN1_WIDTH+IN2_WIDTH+$clog2(IN_SIZE*IN_DEPTH)+HAS_BIAS; ACC_FRAC = IN1_FRAC_WIDTH+IN2_FRAC_WIDTH. All arithmetic is signed.
- Join: data_in1_ready = data_in2_ready = (state==ACCUM). A beat is taken only when both valids are high in ACCUM; a single valid alone is never consumed.
- ACCUM: on each beat, sum_k in1[r,k]*in2[k,c] is added per element. On beat 0 the accumulator loads this sum (no clear cycle). The counter increments per beat; on beat IN_DEPTH-1 the counter wraps to 0 and the state goes to BIAS if HAS_BIAS, else DONE.
- BIAS: bias_ready=1. On bias_valid, each bias element is sign-extended, shifted left by ACC_FRAC-BIAS_FRAC_WIDTH and added; the state goes to DONE. When HAS_BIAS=0, bias_ready is tied to 0.
- DONE: if the out register is empty, or being drained this cycle (data_out_valid&data_out_ready), it loads fixed_round_sat(acc), data_out_valid<=1, and the state goes to ACCUM the same cycle. Otherwise the block stalls in DONE.
- Latency: the tile appears on data_out 2 cycles after the final beat (or bias) handshake if the output is free: 1 cycle into DONE, then registered.
- The output register holds data_out stable while valid&!ready. data_out_valid clears on ready unless a new tile loads the same cycle, which gives back-to-back tiles.
- Rounding: the low s = ACC_FRAC-OUT_FRAC_WIDTH bits are dropped. Mode 1 adds 2^(s-1) before the arithmetic shift; when s=0 no rounding is applied. Saturation clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; wrap mode keeps the low OUT_WIDTH bits.

Decomposition:
- Package fixed_matmul_pkg: state enum {ACCUM, BIAS, DONE}, ROUND_TRUNC/ROUND_HALF_UP constants, acc_width() function.
- Sub-module fixed_round_sat: combinational per-element round, shift and saturate, instantiated OUT_ROWS*OUT_COLUMNS times.
- The top level holds the FSM, counter, MAC array, accumulators and output register.

Test Plan:
- Defaults, all in1=8 (0.5), in2=8, bias=16, 4 beats -> every out=48 (3.0) exactly 2 cycles after the bias handshake.
- All in1=16, in2=16, bias=0 -> acc 8.0: SATURATE=1 gives 127 (0x7F); SATURATE=0 gives 0x80.
- One nonzero product in1[0]=1, in2[0]=8 (raw 8 at frac8): ROUND_MODE=1 -> out[0]=1, mode 0 -> 0. With in1[0]=0xFF: mode 1 -> 0, mode 0 -> 0xFF.
- Hold data_out_ready=0 after tile 1 and stream tile 2: tile 2 stalls in DONE with input readys low and data_out constant. Raising ready gives tile 1 then tile 2 on consecutive cycles.
- Random valid bubbles, including in1 valid without in2 valid -> no beat consumed and results identical to the bubble-free run.
- Assert rst_n low after beat 2 of a tile -> valid=0 and readys low during reset. After release, the next full tile produces the correct, uncontaminated result.
